mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit directly downstream of the processor core.
- Consumes the core's register operands (port-A data and the selected operand B) on a one-cycle start pulse.
- Returns a single-cycle result-ready handshake with a 32-bit result and an exception flag.
- Runs on the processor clock; the core stalls on busy and writes data_result back to the regfile when data_resultRDY is high.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH

Ports:
clock  input  1  processor clock, rising-edge
reset  input  1  asynchronous, active-low (0 = reset asserted)
ctrl_MULT  input  1  start signed multiply; sampled on a rising edge
ctrl_DIV  input  1  start signed divide; sampled on a rising edge
data_operandA  input  WIDTH  multiplicand / dividend
data_operandB  input  WIDTH  multiplier / divisor
data_result  output  WIDTH  low WIDTH bits of product, or quotient
data_exception  output  1  overflow or divide-by-zero; valid with data_resultRDY
data_resultRDY  output  1  one-cycle pulse; result and exception valid
busy  output  1  high while an operation is in progress (MUL/DIV states)

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (reset=0, asynchronous):
  - state=IDLE, iteration counter=0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Internal operand/accumulator registers cleared.
- Start:
  - Accepted only in IDLE or DONE, on rising edge E0 with ctrl_MULT or ctrl_DIV high.
  - Both operands are latched at E0; later operand changes have no effect.
  - Both ctrl lines high: MULT wins.
  - Start pulses in MUL/DIV are ignored and have no side effects.
- Iteration:
  - One radix-2 step per edge, E1..E(WIDTH). Counter runs 0..WIDTH-1; busy=1 throughout.
  - MUL: shift-add on magnitudes, or Booth. Internal product is 2*WIDTH bits.
  - DIV: restoring or non-restoring on magnitudes, then sign correction.
- Completion at edge E(WIDTH+1): state=DONE, data_resultRDY=1 for exactly one cycle, busy=0.
  - Latency is fixed at WIDTH+1 edges for every operand value, including divide-by-zero.
- Hold rules:
  - data_result and data_exception update only at the completion edge.
  - They hold their values until the next completion or reset.
- Leaving DONE: on the next edge, go to IDLE, or to MUL/DIV if a start is present (back-to-back issue).
  - data_resultRDY drops on that edge in both cases.
- Multiply arithmetic:
  - data_result = product[WIDTH-1:0].
  - data_exception=1 iff the full signed product does not fit in WIDTH bits, i.e. product[2*WIDTH-1:WIDTH-1] is not all-equal.
- Divide arithmetic:
  - Quotient truncates toward zero; remainder is discarded.
  - Divisor = 0: data_result=0, data_exception=1.
  - Dividend = most-negative and divisor = -1: data_result=most-negative (0x80000000), data_exception=1.
  - Otherwise data_exception=0.
- Reset mid-operation: abort immediately to IDLE with all outputs 0. No data_resultRDY pulse is produced for the aborted operation.
- Only one operation is in flight at a time. There is no queue; the core must not issue while busy.

Test Plan:
- Reset released, ctrl_MULT pulse with A=7, B=-3 (0xFFFFFFFD) -> busy high E1..E32; data_resultRDY one cycle after E33; data_result=0xFFFFFFEB, exception=0.
- MULT A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1. MULT A=0x80000000, B=1 -> 0x80000000, exception=0.
- ctrl_DIV A=-7, B=2 -> result 0xFFFFFFFD (-3), exception=0. DIV A=100, B=7 -> 14, exception=0.
- DIV A=5, B=0 -> result 0, exception=1 after exactly 33 edges. DIV A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception=1.
- Start MULT 6*7; at E5 pulse ctrl_DIV with new operands -> ignored, result 42 at E33. In the DONE cycle pulse ctrl_DIV 42/6 -> accepted, RDY low next cycle, result 7 at E33 relative to the new start.
- Start MULT; drive reset=0 between edges at cycle 10 -> all outputs 0 immediately, no data_resultRDY ever. After release a fresh MULT 3*3 returns 9.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: one radix-2 step per clock, fixed WIDTH+1 cycle latency.
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// MUL   | shift-add steps on operand magnitudes, then sign fix-up
// DIV   | restoring-division steps on magnitudes, then sign fix-up
// DONE  | result presented with one-cycle data_resultRDY; may accept a new start
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic               steps_done;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mag_b;
   logic               neg_res;
   logic               div_zero;
   logic               div_ovf;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH:0]     prod_top;
   logic               mul_exc;
   logic [WIDTH-1:0]   quo_s;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (-v) : v;
   endfunction

   // acc is shared: MUL keeps {partial product, multiplier}, DIV keeps {remainder, dividend/quotient}
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : {WIDTH{1'b0}})};
   assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, mag_b};

   assign prod_s    = neg_res ? (-acc) : acc;
   assign prod_top  = prod_s[2*WIDTH-1:WIDTH-1];
   assign mul_exc   = !((&prod_top) || !(|prod_top));
   assign quo_s     = neg_res ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (ctrl_MULT)     state_nxt = MUL;
            else if (ctrl_DIV) state_nxt = DIV;
            else               state_nxt = IDLE;
         end
         MUL, DIV: begin
            busy = 1'b1;
            if (steps_done) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         steps_done     <= 1'b0;
         acc            <= '0;
         mag_b          <= '0;
         neg_res        <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         state          <= state_nxt;
         data_resultRDY <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (ctrl_MULT || ctrl_DIV) begin
                  cnt        <= '0;
                  steps_done <= 1'b0;
                  acc        <= {{WIDTH{1'b0}}, mag(data_operandA)};
                  mag_b      <= mag(data_operandB);
                  neg_res    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                  div_zero   <= (data_operandB == '0);
                  div_ovf    <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                (data_operandB == {WIDTH{1'b1}});
               end
            end
            MUL, DIV: begin
               if (steps_done) begin
                  steps_done     <= 1'b0;
                  data_resultRDY <= 1'b1;
                  if (state == MUL) begin
                     data_result    <= prod_s[WIDTH-1:0];
                     data_exception <= mul_exc;
                  end else if (div_zero) begin
                     data_result    <= '0;
                     data_exception <= 1'b1;
                  end else begin
                     data_result    <= quo_s;
                     data_exception <= div_ovf;
                  end
               end else begin
                  if (state == MUL) begin
                     acc <= {mul_sum, acc[WIDTH-1:1]};
                  end else if (!div_trial[WIDTH]) begin
                     acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                  end
                  if (cnt == CNT_LAST) steps_done <= 1'b1;
                  else                 cnt        <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: randomized and directed ops against a plain-arithmetic model.
module tb_mult_div_unit;

   localparam int WIDTH = 32;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              ctrl_MULT = 1'b0;
   logic              ctrl_DIV = 1'b0;
   logic [WIDTH-1:0]  data_operandA = '0;
   logic [WIDTH-1:0]  data_operandB = '0;
   logic [WIDTH-1:0]  data_result;
   logic              data_exception;
   logic              data_resultRDY;
   logic              busy;

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] result;
      logic        exc;
      int          due;
      string       tag;
   } exp_t;

   exp_t        sbq[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          edge_cnt = 0;
   logic [31:0] last_result = '0;
   logic        last_exc = 1'b0;

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [32:0] model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
      longint      p;
      int          sa, sb;
      logic [31:0] r;
      logic        x;
      if (!is_div) begin
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         x = (p != longint'($signed(r)));
      end else if (b == 32'd0) begin
         r = 32'd0;
         x = 1'b1;
      end else if (a == MIN_NEG && b == 32'hFFFF_FFFF) begin
         r = MIN_NEG;
         x = 1'b1;
      end else begin
         sa = a;
         sb = b;
         r = sa / sb;
         x = 1'b0;
      end
      return {x, r};
   endfunction

   // Monitor: every result handshake must match the oldest outstanding expectation, on time.
   always @(negedge clock) begin
      if (data_resultRDY) begin
         if (sbq.size() == 0) begin
            check("unexpected_rdy", 64'(data_resultRDY), 64'(0));
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check({e.tag, "_result"}, 64'(data_result), 64'(e.result));
            check({e.tag, "_exc"}, 64'(data_exception), 64'(e.exc));
            check({e.tag, "_latency"}, 64'(edge_cnt), 64'(e.due));
            check({e.tag, "_busy_at_rdy"}, 64'(busy), 64'(0));
            last_result = e.result;
            last_exc = e.exc;
         end
      end
   end

   // Drive a start; when now=0 we first step to a fresh negedge.
   task automatic issue(input bit now, input bit is_div, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
      logic [32:0] m;
      exp_t e;
      if (!now) @(negedge clock);
      ctrl_MULT = !is_div;
      ctrl_DIV = is_div;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      m = model(is_div, a, b);
      e.result = m[31:0];
      e.exc = m[32];
      e.due = edge_cnt + WIDTH + 2;
      e.tag = tag;
      sbq.push_back(e);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Returns at the negedge where data_resultRDY is seen (the DONE cycle).
   task automatic wait_rdy(output int busy_cycles);
      bit seen = 0;
      busy_cycles = 0;
      for (int i = 0; i < WIDTH + 10 && !seen; i++) begin
         @(negedge clock);
         if (data_resultRDY) seen = 1;
         else if (busy) busy_cycles++;
      end
      if (!seen) begin
         check("rdy_timeout", 64'(0), 64'(1));
         sbq.delete();
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return MIN_NEG;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 200)) - 32'd100;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int bc;
      int rdy_seen;
      logic [31:0] ra, rb;

      #1;
      check("reset_result", 64'(data_result), 64'(0));
      check("reset_exc", 64'(data_exception), 64'(0));
      check("reset_rdy", 64'(data_resultRDY), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      repeat (2) @(negedge clock);
      reset = 1'b1;

      issue(0, 0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
      check("busy_after_start", 64'(busy), 64'(1));
      wait_rdy(bc);
      check("busy_cycles", 64'(bc), 64'(WIDTH + 1));
      @(negedge clock);
      check("rdy_one_cycle", 64'(data_resultRDY), 64'(0));

      issue(0, 0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
      wait_rdy(bc);
      issue(0, 0, MIN_NEG, 32'd1, "mul_minx1");
      wait_rdy(bc);
      issue(0, 1, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
      wait_rdy(bc);
      issue(0, 1, 32'd100, 32'd7, "div_100/7");
      wait_rdy(bc);
      issue(0, 1, 32'd5, 32'd0, "div_by_zero");
      wait_rdy(bc);
      issue(0, 1, MIN_NEG, 32'hFFFF_FFFF, "div_min/-1");
      wait_rdy(bc);

      // Hold: outputs keep the last result while idle
      repeat (3) @(negedge clock);
      check("hold_result", 64'(data_result), 64'(last_result));
      check("hold_exc", 64'(data_exception), 64'(last_exc));

      // Start during MUL is ignored; start in DONE is accepted back-to-back
      issue(0, 0, 32'd6, 32'd7, "mul_6x7_ignore");
      repeat (4) @(negedge clock);
      ctrl_DIV = 1'b1;
      data_operandA = 32'd1000;
      data_operandB = 32'd3;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      wait_rdy(bc);
      issue(1, 1, 32'd42, 32'd6, "div_b2b");
      check("b2b_rdy_low", 64'(data_resultRDY), 64'(0));
      check("b2b_busy", 64'(busy), 64'(1));
      wait_rdy(bc);

      // Asynchronous reset mid-operation
      issue(0, 0, 32'd12345, 32'd678, "mul_aborted");
      repeat (9) @(posedge clock);
      #2;
      reset = 1'b0;
      sbq.delete();
      #1;
      check("abort_result", 64'(data_result), 64'(0));
      check("abort_exc", 64'(data_exception), 64'(0));
      check("abort_rdy", 64'(data_resultRDY), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      repeat (3) @(negedge clock);
      reset = 1'b1;
      rdy_seen = 0;
      for (int i = 0; i < WIDTH + 8; i++) begin
         @(negedge clock);
         if (data_resultRDY) rdy_seen++;
      end
      check("abort_no_rdy", 64'(rdy_seen), 64'(0));
      issue(0, 0, 32'd3, 32'd3, "mul_3x3");
      wait_rdy(bc);

      // Randomized mix, with occasional back-to-back issue from DONE
      for (int i = 0; i < 40; i++) begin
         ra = pick_operand();
         rb = pick_operand();
         issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ra, rb, "rand");
         wait_rdy(bc);
      end

      repeat (3) @(negedge clock);
      check("scoreboard_drained", 64'(sbq.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
